// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply / restoring divide
// on operand magnitudes, sign fix-up stage, valid/ready result handshake to writeback.
module muldiv_unit #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_funct3,
   input  logic [XLEN-1:0]  in_rs1,
   input  logic [XLEN-1:0]  in_rs2,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_result,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   typedef enum logic [2:0] {
      F3_MUL   = 3'd0,
      F3_MULH  = 3'd1,
      F3_MULSU = 3'd2,
      F3_MULU  = 3'd3,
      F3_DIV   = 3'd4,
      F3_DIVU  = 3'd5,
      F3_REM   = 3'd6,
      F3_REMU  = 3'd7
   } funct3_t;

   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   state_t            state, state_next;
   funct3_t           op_r;
   logic              sign_a_r, neg_r;
   logic [XLEN-1:0]   b_r, hi, lo;
   logic [5:0]        cnt;

   logic              accept, sign_a_in, sign_b_in, div_zero, div_ovf, fast_in;
   logic [XLEN-1:0]   fast_res;
   logic [XLEN:0]     mul_sum, div_shift;
   logic              div_ge;
   logic [XLEN-1:0]   div_rem_next;
   logic [2*XLEN-1:0] prod_signed;
   logic [XLEN-1:0]   fix_res;

   // Issue-side decode: operand signs, fast-path detection and fast-path result
   always_comb begin
      in_ready  = !rst && (state == IDLE);
      busy      = (state != IDLE);
      accept    = in_valid && in_ready && !flush;
      sign_a_in = in_rs1[XLEN-1] && (in_funct3 == F3_MULH || in_funct3 == F3_MULSU ||
                                     in_funct3 == F3_DIV  || in_funct3 == F3_REM);
      sign_b_in = in_rs2[XLEN-1] && (in_funct3 == F3_MULH || in_funct3 == F3_DIV ||
                                     in_funct3 == F3_REM);
      div_zero  = in_funct3[2] && (in_rs2 == '0);
      div_ovf   = (in_funct3 == F3_DIV || in_funct3 == F3_REM) &&
                  (in_rs1 == INT_MIN) && (in_rs2 == '1);
      fast_in   = div_zero || div_ovf;
      if (div_zero)
         fast_res = in_funct3[1] ? in_rs1 : '1;
      else
         fast_res = in_funct3[1] ? '0 : INT_MIN;
   end

   // Iteration datapath; hi/lo double as product halves or remainder/quotient
   always_comb begin
      mul_sum      = {1'b0, hi} + (lo[0] ? {1'b0, b_r} : '0);
      div_shift    = {hi, lo[XLEN-1]};
      div_ge       = (div_shift >= {1'b0, b_r});
      div_rem_next = div_ge ? XLEN'(div_shift - {1'b0, b_r}) : div_shift[XLEN-1:0];
      prod_signed  = neg_r ? -{hi, lo} : {hi, lo};
      fix_res      = '0;
      case (op_r)
         F3_MUL:                      fix_res = prod_signed[XLEN-1:0];
         F3_MULH, F3_MULSU, F3_MULU:  fix_res = prod_signed[2*XLEN-1:XLEN];
         F3_DIV, F3_DIVU:             fix_res = neg_r ? -lo : lo;
         F3_REM, F3_REMU:             fix_res = sign_a_r ? -hi : hi;
         default:                     fix_res = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (accept) state_next = fast_in ? DONE : CALC;
         CALC: if (cnt == 6'(XLEN-1)) state_next = FIX;
         FIX:  state_next = DONE;
         DONE: if (out_valid && out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (flush)
         state_next = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_r       <= F3_MUL;
         sign_a_r   <= 1'b0;
         neg_r      <= 1'b0;
         b_r        <= '0;
         hi         <= '0;
         lo         <= '0;
         cnt        <= '0;
         out_valid  <= 1'b0;
         out_result <= '0;
         out_tag    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op_r     <= funct3_t'(in_funct3);
                  sign_a_r <= sign_a_in;
                  neg_r    <= sign_a_in ^ sign_b_in;
                  b_r      <= sign_b_in ? -in_rs2 : in_rs2;
                  lo       <= sign_a_in ? -in_rs1 : in_rs1;
                  hi       <= '0;
                  cnt      <= '0;
                  out_tag  <= in_tag;
                  if (fast_in)
                     out_result <= fast_res;
               end
            end
            CALC: begin
               cnt <= cnt + 6'd1;
               if (op_r[2]) begin
                  hi <= div_rem_next;
                  lo <= {lo[XLEN-2:0], div_ge};
               end else begin
                  hi <= mul_sum[XLEN:1];
                  lo <= {mul_sum[0], lo[XLEN-1:1]};
               end
            end
            FIX:     out_result <= fix_res;
            default: ;
         endcase

         // out_valid trails DONE entry by one register stage
         if (flush || (out_valid && out_ready))
            out_valid <= 1'b0;
         else if (state == DONE)
            out_valid <= 1'b1;
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, out_ready;
   logic        in_ready, out_valid, busy;
   logic [2:0]  in_funct3;
   logic [31:0] in_rs1, in_rs2, out_result;
   logic [4:0]  in_tag, out_tag;

   int checks   = 0;
   int failures = 0;

   muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_tag(out_tag), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
      end
   endtask

   // RV32M semantics from plain 64-bit arithmetic
   function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
      longint      sa, sb, ua, ub;
      logic [63:0] p;
      logic [31:0] r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      r  = '0;
      case (f)
         3'd0: begin p = ua * ub; r = p[31:0];  end
         3'd1: begin p = sa * sb; r = p[63:32]; end
         3'd2: begin p = sa * ub; r = p[63:32]; end
         3'd3: begin p = ua * ub; r = p[63:32]; end
         3'd4: begin
            if (b == 32'd0) r = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
            else begin p = sa / sb; r = p[31:0]; end
         end
         3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 32'd0) r = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
            else begin p = sa % sb; r = p[31:0]; end
         end
         default: r = (b == 32'd0) ? a : a % b;
      endcase
      return r;
   endfunction

   function automatic int exp_latency(input logic [2:0] f, input logic [31:0] a,
                                      input logic [31:0] b);
      if (f[2] && (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
         return 1;
      return 34;
   endfunction

   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag);
      @(negedge clk);
      chk("in_ready_at_issue", {31'd0, in_ready}, 32'd1);
      in_valid  = 1'b1;
      in_funct3 = f;
      in_rs1    = a;
      in_rs2    = b;
      in_tag    = tag;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      in_funct3 = 3'($urandom);
      in_rs1    = $urandom;
      in_rs2    = $urandom;
      in_tag    = 5'($urandom);
   endtask

   task automatic issue_and_wait(input string name, input logic [2:0] f, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] tag);
      int lat;
      issue(f, a, b, tag);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (out_valid !== 1'b1 && lat < 100);
      chk({name, "_latency"}, 32'(lat), 32'(exp_latency(f, a, b)));
      chk({name, "_result"}, out_result, ref_model(f, a, b));
      chk({name, "_tag"}, {27'd0, out_tag}, {27'd0, tag});
   endtask

   task automatic handshake(input string name);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk({name, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
      chk({name, "_in_ready_after"}, {31'd0, in_ready}, 32'd1);
   endtask

   task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag);
      issue_and_wait(name, f, a, b, tag);
      handshake(name);
   endtask

   task automatic no_valid_window(input string name, input int cycles);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         if (out_valid !== 1'b0) seen = 1'b1;
      end
      chk({name, "_no_valid"}, {31'd0, seen}, 32'd0);
   endtask

   initial begin
      logic [2:0]  rf;
      logic [31:0] ra, rb;
      logic [4:0]  rt;

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_funct3 = '0; in_rs1 = '0; in_rs2 = '0; in_tag = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_out_result", out_result, 32'd0);
      chk("reset_out_tag", {27'd0, out_tag}, 32'd0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
      rst = 1'b0;
      #1;
      chk("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

      run_op("mul_7_m3",    3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);
      run_op("mulh_min",    3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1);
      run_op("mulsu_m1",    3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
      run_op("mulu_max",    3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
      run_op("mul_m1",      3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4);
      run_op("div_m7_2",    3'd4, 32'hFFFF_FFF9, 32'd2, 5'd6);
      run_op("rem_m7_2",    3'd6, 32'hFFFF_FFF9, 32'd2, 5'd7);
      run_op("divu_m7_2",   3'd5, 32'hFFFF_FFF9, 32'd2, 5'd8);
      run_op("remu_m7_2",   3'd7, 32'hFFFF_FFF9, 32'd2, 5'd9);
      run_op("div_by_zero", 3'd4, 32'd5, 32'd0, 5'd10);
      run_op("remu_by_zero",3'd7, 32'd5, 32'd0, 5'd11);
      run_op("div_ovf",     3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
      run_op("rem_ovf",     3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13);

      // Backpressure in DONE
      out_ready = 1'b0;
      issue_and_wait("bp", 3'd1, 32'h1234_5678, 32'hFEDC_BA98, 5'd21);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_hold_result", out_result, ref_model(3'd1, 32'h1234_5678, 32'hFEDC_BA98));
         chk("bp_hold_tag", {27'd0, out_tag}, 32'd21);
         chk("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
         chk("bp_hold_busy", {31'd0, busy}, 32'd1);
      end
      handshake("bp");
      run_op("bp_second", 3'd4, 32'hFFFF_0000, 32'd37, 5'd22);

      // Flush at CALC count 10
      issue(3'd5, $urandom, $urandom | 32'd1, 5'd23);
      repeat (9) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
      chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
      chk("flush_busy", {31'd0, busy}, 32'd0);
      no_valid_window("flush", 40);

      // Reset mid-operation
      issue(3'd0, 32'd3, 32'd9, 5'd24);
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_mid_out_result", out_result, 32'd0);
      chk("rst_mid_out_tag", {27'd0, out_tag}, 32'd0);
      chk("rst_mid_busy", {31'd0, busy}, 32'd0);
      chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
      rst = 1'b0;
      no_valid_window("rst_mid", 40);

      // Flush coincident with an issue request in IDLE
      @(negedge clk);
      in_valid = 1'b1; flush = 1'b1;
      in_funct3 = 3'd0; in_rs1 = 32'd3; in_rs2 = 32'd4; in_tag = 5'd25;
      @(posedge clk);
      #1;
      in_valid = 1'b0; flush = 1'b0;
      chk("flush_issue_busy", {31'd0, busy}, 32'd0);
      chk("flush_issue_in_ready", {31'd0, in_ready}, 32'd1);
      no_valid_window("flush_issue", 40);
      run_op("after_flush_issue", 3'd0, 32'd3, 32'd4, 5'd26);

      // Randomized ops with boundary operands mixed in
      for (int n = 0; n < 32; n++) begin
         rf = 3'($urandom);
         ra = $urandom;
         rb = $urandom;
         rt = 5'($urandom);
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: rb = 32'($urandom_range(1, 15));
            3: ra = 32'hFFFF_FFFF;
            default: ;
         endcase
         run_op("rand", rf, ra, rb, rt);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
